// File: rtl/regwr_arb.sv
// Round-robin arbiter that merges three register-write requesters onto the two
// register-file write ports, honouring the status-register and PC write blocks.
module regwr_arb #(
    parameter int addrsize = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              req,
    input  logic [3*addrsize-1:0]   req_addr,
    input  logic [95:0]             req_data,
    input  logic                    stwr_pend,
    input  logic                    pcincr_pend,
    output logic [2:0]              ack,
    output logic [1:0]              write,
    output logic [addrsize-1:0]     wa0,
    output logic [addrsize-1:0]     wa1,
    output logic [31:0]             wd0,
    output logic [31:0]             wd1
);

    localparam int nreq = 3;
    localparam logic [addrsize-1:0] st_addr = addrsize'(28);
    localparam logic [addrsize-1:0] pc_addr = addrsize'(31);

    logic [addrsize-1:0] addr [nreq];
    logic [31:0]         data [nreq];
    logic [nreq-1:0]     elig;

    logic [1:0]      rr;
    logic [1:0]      rr_eff;
    logic [1:0]      rr_next;
    logic [1:0]      sel0;
    logic [1:0]      sel1;
    logic [1:0]      last;
    logic [1:0]      idx;
    logic [2:0]      sum;
    logic            g0;
    logic            g1;
    logic [nreq-1:0] grant;

    always_comb begin
        for (int i = 0; i < nreq; i++) begin
            addr[i] = req_addr[i*addrsize +: addrsize];
            data[i] = req_data[i*32 +: 32];
            elig[i] = req[i]
                      && !(addr[i] == st_addr && stwr_pend)
                      && !(addr[i] == pc_addr && pcincr_pend);
        end
    end

    // Scan from rr; requesters colliding with the port-0 address are skipped.
    always_comb begin
        rr_eff = (rr == 2'd3) ? 2'd0 : rr;
        g0     = 1'b0;
        g1     = 1'b0;
        sel0   = 2'd0;
        sel1   = 2'd0;
        last   = rr_eff;
        grant  = '0;
        idx    = 2'd0;
        sum    = 3'd0;
        for (int k = 0; k < nreq; k++) begin
            sum = {1'b0, rr_eff} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (elig[idx]) begin
                if (!g0) begin
                    g0          = 1'b1;
                    sel0        = idx;
                    grant[idx]  = 1'b1;
                    last        = idx;
                end else if (!g1 && addr[idx] != addr[sel0]) begin
                    g1          = 1'b1;
                    sel1        = idx;
                    grant[idx]  = 1'b1;
                    last        = idx;
                end
            end
        end
        rr_next = (last == 2'd2) ? 2'd0 : last + 2'd1;
        ack     = rst ? 3'b000 : grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr    <= 2'd0;
            write <= 2'b00;
            wa0   <= '0;
            wa1   <= '0;
            wd0   <= '0;
            wd1   <= '0;
        end else begin
            write <= {g1, g0};
            if (g0) begin
                wa0 <= addr[sel0];
                wd0 <= data[sel0];
                rr  <= rr_next;
            end
            if (g1) begin
                wa1 <= addr[sel1];
                wd1 <= data[sel1];
            end
        end
    end

endmodule

// File: tb/tb_regwr_arb.sv
// Scoreboard bench for regwr_arb: a behavioural arbiter model predicts ack and
// queues the registered port outputs, which are popped one cycle later.
module tb_regwr_arb;

    localparam int aw = 5;

    typedef struct {
        logic [1:0]    write;
        logic [aw-1:0] wa0;
        logic [aw-1:0] wa1;
        logic [31:0]   wd0;
        logic [31:0]   wd1;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      req;
    logic [3*aw-1:0] req_addr;
    logic [95:0]     req_data;
    logic            stwr_pend;
    logic            pcincr_pend;
    logic [2:0]      ack;
    logic [1:0]      write;
    logic [aw-1:0]   wa0;
    logic [aw-1:0]   wa1;
    logic [31:0]     wd0;
    logic [31:0]     wd1;

    int testsRun    = 0;
    int testsFailed = 0;

    exp_t sb[$];

    int            m_rr;
    exp_t          m_out;
    logic [2:0]    cur_req;
    logic [aw-1:0] cur_addr [3];
    logic [31:0]   cur_data [3];
    logic          cur_stp;
    logic          cur_pcp;
    logic [2:0]    last_mack;

    regwr_arb #(.addrsize(aw)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .stwr_pend(stwr_pend), .pcincr_pend(pcincr_pend), .ack(ack),
        .write(write), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_rr        = 0;
        m_out.write = 2'b00;
        m_out.wa0   = '0;
        m_out.wa1   = '0;
        m_out.wd0   = '0;
        m_out.wd1   = '0;
    endtask

    // Build the scan order, list eligible requesters, then pick the two ports.
    task automatic modelArb(output logic [2:0] mack);
        int ord [3];
        int el[$];
        int p0;
        int p1;
        mack = 3'b000;
        p0   = -1;
        p1   = -1;
        for (int k = 0; k < 3; k++) ord[k] = (m_rr + k) % 3;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = ord[k];
            if (cur_req[i] && !(cur_addr[i] == 5'd28 && cur_stp) && !(cur_addr[i] == 5'd31 && cur_pcp))
                el.push_back(i);
        end
        if (el.size() > 0) p0 = el[0];
        for (int j = 1; j < el.size(); j++)
            if (p1 < 0 && cur_addr[el[j]] != cur_addr[p0]) p1 = el[j];
        m_out.write = {p1 >= 0, p0 >= 0};
        if (p0 >= 0) begin
            mack[p0]  = 1'b1;
            m_out.wa0 = cur_addr[p0];
            m_out.wd0 = cur_data[p0];
            m_rr      = (p0 + 1) % 3;
        end
        if (p1 >= 0) begin
            mack[p1]  = 1'b1;
            m_out.wa1 = cur_addr[p1];
            m_out.wd1 = cur_data[p1];
            m_rr      = (p1 + 1) % 3;
        end
    endtask

    task automatic popCompare();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            checkOutput("write", 32'(write), 32'(e.write));
            checkOutput("wa0",   32'(wa0),   32'(e.wa0));
            checkOutput("wa1",   32'(wa1),   32'(e.wa1));
            checkOutput("wd0",   wd0,        e.wd0);
            checkOutput("wd1",   wd1,        e.wd1);
        end
    endtask

    // Called just after a posedge; drives one cycle and checks both ack and the next outputs.
    task automatic applyStimulus(input logic [2:0] r,
                                 input logic [aw-1:0] a0, input logic [aw-1:0] a1, input logic [aw-1:0] a2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic stp, input logic pcp,
                                 input bit chk, input logic [2:0] spec_ack);
        logic [2:0] mack;
        req         = r;
        req_addr    = {a2, a1, a0};
        req_data    = {d2, d1, d0};
        stwr_pend   = stp;
        pcincr_pend = pcp;
        cur_req     = r;
        cur_addr[0] = a0; cur_addr[1] = a1; cur_addr[2] = a2;
        cur_data[0] = d0; cur_data[1] = d1; cur_data[2] = d2;
        cur_stp     = stp;
        cur_pcp     = pcp;
        @(negedge clk);
        modelArb(mack);
        last_mack = mack;
        checkOutput("ack", 32'(ack), 32'(mack));
        if (chk) checkOutput("ack_spec", 32'(ack), 32'(spec_ack));
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        popCompare();
    endtask

    task automatic applyReset(input logic [2:0] r);
        rst         = 1'b1;
        req         = r;
        req_addr    = {5'd7, 5'd6, 5'd5};
        stwr_pend   = 1'b0;
        pcincr_pend = 1'b0;
        @(negedge clk);
        checkOutput("ack_rst", 32'(ack), 32'd0);
        modelReset();
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        popCompare();
        rst = 1'b0;
    endtask

    logic          pend [3];
    logic [aw-1:0] haddr [3];
    logic [31:0]   hdata [3];

    function automatic logic [aw-1:0] pickAddr();
        case ($urandom_range(0, 5))
            0:       return 5'd28;
            1:       return 5'd31;
            2:       return 5'd9;
            3:       return 5'd10;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        rst         = 1'b1;
        req         = 3'b000;
        req_addr    = '0;
        req_data    = '0;
        stwr_pend   = 1'b0;
        pcincr_pend = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        applyReset(3'b000);
        applyReset(3'b111);

        // All three requesting, distinct addresses, then the rotation through requester 2
        applyStimulus(3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 0, 0, 1, 3'b011);
        applyStimulus(3'b100, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 0, 0, 1, 3'b100);
        applyStimulus(3'b111, 5'd5, 5'd6, 5'd7, 32'hB0, 32'hB1, 32'hB2, 0, 0, 1, 3'b011);

        // Same-address collision from rr=0
        applyReset(3'b000);
        applyStimulus(3'b011, 5'd9, 5'd9, 5'd0, 32'hC0, 32'hC1, 32'hC2, 0, 0, 1, 3'b001);
        applyStimulus(3'b010, 5'd9, 5'd9, 5'd0, 32'hC0, 32'hC1, 32'hC2, 0, 0, 1, 3'b010);

        // Status-register block, then release; idle cycle shows held wa/wd
        applyStimulus(3'b001, 5'd28, 5'd0, 5'd0, 32'hD0, 32'h0, 32'h0, 1, 0, 1, 3'b000);
        applyStimulus(3'b001, 5'd28, 5'd0, 5'd0, 32'hD0, 32'h0, 32'h0, 0, 0, 1, 3'b001);
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 3'b000);

        // PC block on requester 1; pointer lands on 0
        applyStimulus(3'b110, 5'd0, 5'd31, 5'd3, 32'h0, 32'hE1, 32'hE2, 0, 1, 1, 3'b100);
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd4, 32'hF0, 32'hF1, 32'hF2, 0, 0, 1, 3'b011);

        // Reset in the middle of dual-port traffic
        applyStimulus(3'b111, 5'd11, 5'd12, 5'd13, 32'h10, 32'h11, 32'h12, 0, 0, 1, 3'b101);
        applyReset(3'b111);
        applyStimulus(3'b111, 5'd11, 5'd12, 5'd13, 32'h10, 32'h11, 32'h12, 0, 0, 1, 3'b011);

        // Randomised traffic obeying the hold-until-ack handshake
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1'b1;
                    haddr[i] = pickAddr();
                    hdata[i] = $urandom;
                end
            end
            if (c % 97 == 96) begin
                applyReset({pend[2], pend[1], pend[0]});
                for (int i = 0; i < 3; i++) pend[i] = 1'b0;
            end else begin
                applyStimulus({pend[2], pend[1], pend[0]}, haddr[0], haddr[1], haddr[2],
                              hdata[0], hdata[1], hdata[2],
                              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                              0, 3'b000);
                for (int i = 0; i < 3; i++) if (last_mack[i]) pend[i] = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/regwr_arb.md
REGWR_ARB -- requirements
Module: regwr_arb

Interface
REQ-001 Parameter: addrsize, default 5, register address width.
REQ-002 Parameter: nreq, fixed 3, number of write requesters. Not overridable.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  3  write request per requester i (bit i).
REQ-006 req_addr  input  3*addrsize  destination register of requester i, in bits [i*addrsize +: addrsize].
REQ-007 req_data  input  96  write data of requester i, in bits [i*32 +: 32].
REQ-008 ack  output  3  grant pulse per requester, combinational, valid in the grant cycle.
REQ-009 stwr_pend  input  1  status-register write (r28) occurs in the next cycle; blocks address 28.
REQ-010 pcincr_pend  input  1  PC increment (r31) occurs in the next cycle; blocks address 31.
REQ-011 write  output  2  register-file write enables, port 0 and port 1, registered.
REQ-012 wa0, wa1  output  addrsize each  register-file write addresses, registered.
REQ-013 wd0, wd1  output  32 each  register-file write data, registered.

Function
REQ-014 Requester i is eligible when req[i]=1 and its address is not blocked: not (addr==28 and stwr_pend), and not (addr==31 and pcincr_pend).
REQ-015 Round-robin pointer rr (0..2) names the highest-priority requester; scan order is rr, rr+1, rr+2, modulo 3.
REQ-016 Port 0 is granted to the first eligible requester in scan order.
REQ-017 Port 1 is granted to the next eligible requester in scan order whose address differs from the port-0 address.
REQ-018 A requester whose address equals the port-0 address is not granted this cycle; that requester is not a port-1 candidate.
REQ-019 At most 2 ack bits are set per cycle. ack[i]=1 only for granted requesters. ack=0 while rst=1.
REQ-020 Handshake: the requester holds req, addr and data stable until it sees ack. Any value on req in the cycle after ack is a new request.
REQ-021 Latency: a grant in cycle N drives write/wa/wd at the posedge ending cycle N; the outputs are valid during cycle N+1 for exactly one cycle unless re-granted.
REQ-022 Outputs of a port with no grant: write bit=0; wa/wd hold their previous value.
REQ-023 Port 0 granted with port 1 empty: write=2'b01.
REQ-024 Pointer update on each edge with at least one grant: rr <= (index of last granted requester in scan order + 1) mod 3. rr holds when there is no grant.
REQ-025 Fairness: a requester that stays eligible is granted within 2 grant cycles.
REQ-026 Blocked requesters never receive ack. They are re-evaluated each cycle with no penalty to priority.
REQ-027 Wrap: rr=2 advancing by one becomes 0. The encoding value 3 is never reached. If 3 is ever present, it is treated as 0.

Reset
REQ-028 While rst=1 at posedge: rr<=0, write<=2'b00, wa0/wa1<=0, wd0/wd1<=0. No grants are issued.
REQ-029 Reset asserted while a request is pending: the request is dropped without ack. After reset deassertion, arbitration restarts with rr=0.

Verification
REQ-030 After reset, req=3'b111 with addr 5,6,7, no blocks -> ack=3'b011; next cycle write=11, wa0=5, wa1=6, rr=2.
REQ-031 The REQ-030 case continued with req=3'b100, then 3'b111 held -> ack=3'b100, then ack=3'b011. Each requester receives ack within 2 grant cycles.
REQ-032 req=3'b011, both addr 9, rr=0 -> ack=3'b001, write=01, wa0=9. Next cycle req=3'b010 -> ack=3'b010.
REQ-033 req=3'b001 addr 28 with stwr_pend=1 -> ack=0, write=00. stwr_pend=0 next cycle -> ack=3'b001, then wa0=28, write=01.
REQ-034 req=3'b110, addr1=31 with pcincr_pend=1, addr2=3 -> ack=3'b100, wa0=3. rr becomes 0.
REQ-035 rst=1 asserted for one cycle while write=11 and req=3'b111 -> following cycle write=00, wa/wd=0, ack=0 during reset. The first post-reset grant is to requester 0.
